// File: rtl/key_event_arbiter.sv
// key_event_arbiter: per-key press capture with round-robin delivery over valid/ready.
// Auto-repeat events are built in only when KEY_ARB_REPEAT_EN is defined.
module key_event_arbiter #(
  parameter int N_KEYS        = 4,
  parameter int ID_W          = 2,
  parameter int CNT_W         = 24,
  parameter int HOLD_CYCLES   = 10_000_000,
  parameter int REPEAT_CYCLES = 2_500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] keys,
  output logic              evt_valid,
  output logic [ID_W-1:0]   evt_id,
  output logic              evt_repeat,
  input  logic              evt_ready,
  output logic [N_KEYS-1:0] drop_flags,
  input  logic              drop_clr
);

  typedef enum logic [0:0] {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t            state_r;
  logic [N_KEYS-1:0] key_d_r;
  logic [N_KEYS-1:0] pend_r;
  logic [ID_W-1:0]   last_grant_r;
  logic [N_KEYS-1:0] rise_s;
  logic [N_KEYS-1:0] rep_evt_s;
  logic [N_KEYS-1:0] new_evt_s;
  logic [N_KEYS-1:0] take_s;
  logic [N_KEYS-1:0] drop_set_s;
  logic [N_KEYS-1:0] grant_oh_s;
  logic [N_KEYS-1:0] pend_nxt_s;
  logic [N_KEYS-1:0] rr_bits_s;
  logic [ID_W-1:0]   grant_idx_s;
  logic              grant_found_s;
  logic              rr_hit_s;
  logic              accept_s;
  logic              grant_en_s;
  int                rr_pos_s;

  assign rise_s     = keys & ~key_d_r;
  assign new_evt_s  = rise_s | rep_evt_s;
  assign accept_s   = evt_valid & evt_ready;
  assign grant_en_s = grant_found_s & ((state_r == IDLE) | accept_s);
  assign grant_oh_s = grant_en_s ? ({{(N_KEYS-1){1'b0}}, 1'b1} << grant_idx_s)
                                 : {N_KEYS{1'b0}};
  // A key whose pend bit is being granted this cycle can take a fresh event without a drop.
  assign drop_set_s = new_evt_s & pend_r & ~grant_oh_s;
  assign take_s     = new_evt_s & ~drop_set_s;
  assign pend_nxt_s = (pend_r & ~grant_oh_s) | take_s;

  // Round-robin search starting one past the last granted key.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {ID_W{1'b0}};
    rr_pos_s      = 0;
    rr_bits_s     = {N_KEYS{1'b0}};
    rr_hit_s      = 1'b0;
    for (int k = 1; k <= N_KEYS; k++) begin
      rr_pos_s      = (int'(last_grant_r) + k) % N_KEYS;
      rr_bits_s     = pend_r >> rr_pos_s;
      rr_hit_s      = rr_bits_s[0] & ~grant_found_s;
      grant_idx_s   = rr_hit_s ? ID_W'(rr_pos_s) : grant_idx_s;
      grant_found_s = grant_found_s | rr_hit_s;
    end
  end

  // Edge history, pending latches, drop flags and the offer state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      key_d_r      <= {N_KEYS{1'b0}};
      pend_r       <= {N_KEYS{1'b0}};
      last_grant_r <= ID_W'(N_KEYS - 1);
      drop_flags   <= {N_KEYS{1'b0}};
      evt_valid    <= 1'b0;
      evt_id       <= {ID_W{1'b0}};
    end else begin
      key_d_r    <= keys;
      pend_r     <= pend_nxt_s;
      drop_flags <= (drop_flags & ~{N_KEYS{drop_clr}}) | drop_set_s;
      case (state_r)
        IDLE, OFFER: begin
          if (grant_en_s) begin
            state_r      <= OFFER;
            evt_valid    <= 1'b1;
            evt_id       <= grant_idx_s;
            last_grant_r <= grant_idx_s;
          end else if (accept_s) begin
            state_r   <= IDLE;
            evt_valid <= 1'b0;
          end else begin
            state_r   <= state_r;
            evt_valid <= evt_valid;
          end
        end
        default: begin
          state_r   <= IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef KEY_ARB_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_TH = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TH  = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0]  hold_cnt_r [N_KEYS];
  logic [N_KEYS-1:0] rep_phase_r;
  logic [N_KEYS-1:0] pend_rep_r;
  logic [N_KEYS-1:0] held_s;

  assign held_s = keys & key_d_r;

  // Repeat fires when a held key's counter meets the current threshold.
  always_comb begin
    rep_evt_s = {N_KEYS{1'b0}};
    for (int i = 0; i < N_KEYS; i++) begin
      rep_evt_s[i] = held_s[i] & (hold_cnt_r[i] == (rep_phase_r[i] ? REP_TH : HOLD_TH));
    end
  end

  // Hold counters; the threshold switches to the repeat interval after the first fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_KEYS; i++) hold_cnt_r[i] <= {CNT_W{1'b0}};
      rep_phase_r <= {N_KEYS{1'b0}};
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (!held_s[i]) begin
          hold_cnt_r[i]  <= {CNT_W{1'b0}};
          rep_phase_r[i] <= 1'b0;
        end else if (rep_evt_s[i]) begin
          hold_cnt_r[i]  <= {CNT_W{1'b0}};
          rep_phase_r[i] <= 1'b1;
        end else begin
          hold_cnt_r[i]  <= hold_cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Event type travels with the pend bit and is loaded on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_rep_r <= {N_KEYS{1'b0}};
      evt_repeat <= 1'b0;
    end else begin
      pend_rep_r <= (pend_rep_r & ~take_s) | (rep_evt_s & take_s);
      if (grant_en_s) begin
        evt_repeat <= |(pend_rep_r & grant_oh_s);
      end else begin
        evt_repeat <= evt_repeat;
      end
    end
  end
`else
  localparam int unused_cfg = CNT_W + HOLD_CYCLES + REPEAT_CYCLES;

  assign rep_evt_s  = {N_KEYS{1'b0}};
  assign evt_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter: directed scenarios plus random keys/ready against a
// behavioural event model.
module tb_key_event_arbiter;

  localparam int NK   = 4;
  localparam int HOLD = 10;
  localparam int REPC = 4;
`ifdef KEY_ARB_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] keys = 4'b0000;
  logic       evt_ready = 1'b0;
  logic       drop_clr = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_repeat;
  logic [3:0] drop_flags;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit         m_prev [NK];
  bit         m_pend [NK];
  bit         m_prep [NK];
  int         m_held [NK];
  int         m_last;
  bit         m_valid;
  int         m_id;
  bit         m_rep;
  bit [3:0]   m_drop;

  key_event_arbiter #(
    .N_KEYS(NK), .ID_W(2), .CNT_W(8), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .keys(keys),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_repeat(evt_repeat),
    .evt_ready(evt_ready), .drop_flags(drop_flags), .drop_clr(drop_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NK; i++) begin
      m_prev[i] = 1'b0; m_pend[i] = 1'b0; m_prep[i] = 1'b0; m_held[i] = 0;
    end
    m_last = NK - 1; m_valid = 1'b0; m_id = 0; m_rep = 1'b0; m_drop = 4'b0000;
  endtask

  // Drive one cycle of inputs, advance the model by the same cycle, then compare.
  task automatic step(input logic [3:0] k, input logic r, input logic c);
    bit ev [NK];
    bit rp [NK];
    bit accept;
    int g;
    keys = k; evt_ready = r; drop_clr = c;
    for (int i = 0; i < NK; i++) begin
      ev[i] = k[i] && !m_prev[i];
      rp[i] = 1'b0;
      if (k[i] && m_prev[i]) begin
        m_held[i]++;
        if (REP_EN && m_held[i] >= HOLD && (m_held[i] - HOLD) % REPC == 0) rp[i] = 1'b1;
      end else begin
        m_held[i] = 0;
      end
      m_prev[i] = k[i];
    end
    accept = m_valid && r;
    g = -1;
    if (!m_valid || accept) begin
      for (int s = 1; s <= NK; s++) begin
        if (g < 0 && m_pend[(m_last + s) % NK]) g = (m_last + s) % NK;
      end
    end
    if (c) m_drop = 4'b0000;
    if (g >= 0) begin
      m_valid = 1'b1; m_id = g; m_rep = m_prep[g]; m_last = g; m_pend[g] = 1'b0;
    end else if (accept) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < NK; i++) begin
      if (ev[i] || rp[i]) begin
        if (m_pend[i]) m_drop[i] = 1'b1;
        else begin m_pend[i] = 1'b1; m_prep[i] = rp[i]; end
      end
    end
    @(posedge clk);
    #1;
    chk("valid", 32'(evt_valid), 32'(m_valid));
    if (m_valid) begin
      chk("id", 32'(evt_id), 32'(m_id));
      chk("repeat", 32'(evt_repeat), 32'(m_rep));
    end
    chk("drop_flags", 32'(drop_flags), 32'(m_drop));
  endtask

  task automatic do_reset(input logic [3:0] k);
    rst_n = 1'b0; keys = k; evt_ready = 1'b0; drop_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_id", 32'(evt_id), 32'd0);
    chk("rst_repeat", 32'(evt_repeat), 32'd0);
    chk("rst_drop", 32'(drop_flags), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n_press;
    int n_rep;
    int n_after;
    logic [3:0] cur;
    logic [3:0] nk;

    // Single press: offered two cycles later for exactly one cycle
    do_reset(4'b0000);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    chk("lat_first_edge", 32'(evt_valid), 32'd0);
    step(4'b0100, 1'b1, 1'b0);
    chk("lat_valid", 32'(evt_valid), 32'd1);
    chk("lat_id", 32'(evt_id), 32'd2);
    chk("lat_rep", 32'(evt_repeat), 32'd0);
    step(4'b0100, 1'b1, 1'b0);
    chk("lat_one_cycle", 32'(evt_valid), 32'd0);

    // All four keys at once: back-to-back ids 0..3
    do_reset(4'b0000);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    for (int j = 0; j < 4; j++) begin
      step(4'b1111, 1'b1, 1'b0);
      chk("b2b_valid", 32'(evt_valid), 32'd1);
      chk("b2b_id", 32'(evt_id), 32'(j));
    end
    step(4'b1111, 1'b1, 1'b0);
    chk("b2b_drain", 32'(evt_valid), 32'd0);

    // Stalled consumer: repeated presses of key 1 overflow its latch
    do_reset(4'b0000);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    chk("stall_id", 32'(evt_id), 32'd1);
    chk("stall_drop", 32'(drop_flags), 32'b0010);
    step(4'b0010, 1'b0, 1'b1);
    chk("drop_clr", 32'(drop_flags), 32'd0);
    repeat (3) step(4'b0000, 1'b1, 1'b0);

    // Wrap-around: after id 3, keys 0 and 3 pending -> 0 then 3
    do_reset(4'b0000);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    chk("wrap_first", 32'(evt_id), 32'd3);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b1001, 1'b0, 1'b0);
    step(4'b1001, 1'b1, 1'b0);
    chk("wrap_next0", 32'(evt_id), 32'd0);
    step(4'b1001, 1'b1, 1'b0);
    chk("wrap_next3", 32'(evt_id), 32'd3);
    step(4'b0000, 1'b1, 1'b0);

    // Key 0 held for 30 cycles: one press, repeats only when the feature is built in
    do_reset(4'b0000);
    step(4'b0000, 1'b1, 1'b0);
    n_press = 0; n_rep = 0; n_after = 0;
    for (int j = 0; j < 30; j++) begin
      step(4'b0001, 1'b1, 1'b0);
      if (evt_valid && !evt_repeat) n_press++;
      if (evt_valid && evt_repeat) n_rep++;
    end
    for (int j = 0; j < 10; j++) begin
      step(4'b0000, 1'b1, 1'b0);
      if (evt_valid) n_after++;
    end
    chk("hold_press_cnt", 32'(n_press), 32'd1);
    chk("hold_rep_cnt", 32'(n_rep), REP_EN ? 32'd5 : 32'd0);
    chk("hold_after_release", 32'(n_after), 32'd0);

    // Asynchronous reset while an event is offered and a drop flag is set
    do_reset(4'b0000);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    chk("pre_rst_drop", 32'(drop_flags), 32'b0100);
    keys = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(evt_valid), 32'd0);
    chk("async_id", 32'(evt_id), 32'd0);
    chk("async_drop", 32'(drop_flags), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step(4'b0000, 1'b1, 1'b0);
      chk("post_rst_idle", 32'(evt_valid), 32'd0);
    end

    // Random phase; keys high at reset release produce press events
    cur = 4'b1010;
    do_reset(cur);
    for (int j = 0; j < 800; j++) begin
      nk = cur;
      for (int b = 0; b < NK; b++) begin
        if ($urandom_range(0, 7) == 0) nk[b] = ~nk[b];
      end
      cur = nk;
      step(cur, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
